// File: rtl/mem_reader_if.sv
// Read-port and output-stream bundle between mem_reader, its memory and its consumer.
// master = mem_reader side; slave = memory/consumer side.
interface mem_reader_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic                  mem_r_en;
   logic [ADDR_WIDTH-1:0] mem_r_addr;
   logic [DATA_WIDTH-1:0] mem_r_data;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output mem_r_en, mem_r_addr, out_data, out_valid,
      input  mem_r_data, out_ready
   );

   modport slave (
      input  mem_r_en, mem_r_addr, out_data, out_valid,
      output mem_r_data, out_ready
   );
endinterface

// File: rtl/mem_reader.sv
// Walks [first_addr..last_addr] (wrapping) over a sync-read memory, one word per 3 cycles.
// Latency start->out_valid 2 cycles; stalls in SEND holding out_data while out_ready is low.
module mem_reader #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] first_addr,
   input  logic [ADDR_WIDTH-1:0] last_addr,
   output logic                  busy,
   output logic                  done,
   mem_reader_if.master          bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_CAPTURE,
      ST_SEND,
      ST_DONE
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] cur;
   logic [ADDR_WIDTH-1:0] stop_addr;
   logic                  r_en;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cur       <= '0;
         stop_addr <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         r_en      <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         done <= 1'b0;
         r_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cur       <= first_addr;
                  stop_addr <= last_addr;
                  r_en      <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               data_q  <= bus.mem_r_data;
               valid_q <= 1'b1;
               state   <= ST_SEND;
            end
            ST_SEND: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  if (cur == stop_addr) begin
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     // read enable is registered so the next ISSUE cycle drives it
                     cur   <= cur + ADDR_WIDTH'(1);
                     r_en  <= 1'b1;
                     state <= ST_ISSUE;
                  end
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.mem_r_en   = r_en;
   assign bus.mem_r_addr = cur;
   assign bus.out_data   = data_q;
   assign bus.out_valid  = valid_q;

endmodule

// File: doc/mem_reader.md
# mem_reader

Sequential read-out engine for the team's synchronous-read `memory` block. It walks an address range, drives the memory's read port, and streams each word out on a valid/ready interface. It sits between a memory instance and a byte consumer such as a UART transmitter or debug dump path. It is the read-side counterpart to the logic that writes and initialises the memory.

## Interface
- `ADDR_WIDTH`, default 4: memory address width; the address space is 2^ADDR_WIDTH words.
- `DATA_WIDTH`, default 8: memory word width.

- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a scan; sampled only in IDLE.
- `first_addr`  in  ADDR_WIDTH: first address to read; latched when `start` is accepted.
- `last_addr`  in  ADDR_WIDTH: last address to read, inclusive; latched when `start` is accepted.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse after the last word's handshake.
- `mem_r_en`  out  1: memory read enable.
- `mem_r_addr`  out  ADDR_WIDTH: memory read address.
- `mem_r_data`  in  DATA_WIDTH: memory read data, valid 1 cycle after the edge that samples `mem_r_en`.
- `out_data`  out  DATA_WIDTH: streamed word.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: consumer accepts the word.

## Operation
- States: IDLE, ISSUE, CAPTURE, SEND, DONE.
- IDLE:
  - `start`=1 latches `first_addr` into the current address `cur` and `last_addr` into `end`.
  - Next state is ISSUE.
- ISSUE:
  - `mem_r_en`=1 and `mem_r_addr`=`cur` for exactly one cycle.
  - Next state is CAPTURE.
- CAPTURE:
  - `mem_r_data` is registered into `out_data`.
  - `out_valid` is set at the same edge.
  - Next state is SEND.
- SEND:
  - `out_valid`=1; `out_data` is held stable until the handshake.
  - Handshake is `out_valid`&`out_ready` at a rising edge.
  - On handshake with `cur`==`end`: next state is DONE and `out_valid` clears.
  - On handshake otherwise: `cur` <= `cur`+1 modulo 2^ADDR_WIDTH, `out_valid` clears, next state is ISSUE.
- DONE:
  - `done`=1 for one cycle.
  - Next state is IDLE.
- Range rules:
  - Words transferred = ((`end`−`cur`₀) mod 2^ADDR_WIDTH) + 1.
  - `first`==`last` transfers exactly 1 word.
  - `last`<`first` wraps through address 2^ADDR_WIDTH−1 to 0.
  - `first`==`last`+1 (mod) transfers all 2^ADDR_WIDTH words.
- `start` outside IDLE is ignored; the latched range is not disturbed.
- `mem_r_en` is never asserted outside ISSUE, so there is exactly one read per word and no read during a stall.
- `mem_r_addr` holds `cur` in all states; it is 0 after reset.
- No write port; the memory's write side is owned elsewhere.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `mem_r_en`=0, `mem_r_addr`=0, `out_data`=0, `out_valid`=0.
- `rst` takes priority over all other inputs.
- `rst` asserted mid-scan:
  - The next edge returns to IDLE with the reset values above.
  - No `done` pulse is generated.
  - A partially offered word is dropped.
- `start` sampled at edge k:
  - `busy`=1 and `mem_r_en`=1 from edge k.
  - `out_valid`=1 from edge k+2.
- Per-word period is 3 cycles with `out_ready` held high: ISSUE, CAPTURE, SEND.
- Each cycle of `out_ready`=0 in SEND adds one cycle.
- `done` rises at the edge after the last handshake; `busy` falls one edge later.
- A new `start` is accepted in the cycle after `done` (IDLE).

## Test plan
- Memory preloaded so that address i holds 0xA0+i. Apply `rst` for 2 cycles → all outputs are 0. Then `start` with first=0, last=15, `out_ready`=1 → 16 words 0xA0..0xAF, one every 3 cycles; first `out_valid` 2 cycles after `start` is sampled; a single `done` pulse.
- first=2, last=4, `out_ready`=0 for 5 cycles while 0xA3 is offered → `out_data` is stable at 0xA3 throughout the stall, `mem_r_en` stays 0 during the stall, and the full stream is 0xA2, 0xA3, 0xA4.
- Wrap scan with first=14, last=1 → 0xAE, 0xAF, 0xA0, 0xA1 (4 words). Single-word scan with first=last=7 → only 0xA7, then `done`.
- Full-range scan with first=5, last=4 → 16 words 0xA5..0xAF then 0xA0..0xA4.
- Pulse `start` with first=0 while a scan with first=8, last=9 is active → output is still 0xA8, 0xA9. Assert `rst` during the second word → `busy`=0 and `out_valid`=0 after one edge with no `done`; a following `start` with first=last=3 yields 0xA3.
